// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: constants shared by the data-memory responder and the core.
//   - funct3 encodings for loads and stores
//   - MEM_DELAY_CONST: default access latency, also used by the control
//     unit's counter
//   - dmem_state_t: responder FSM states
package dmem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int MEM_DELAY_CONST = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: MEM-stage request/response bundle between the core and
// the data-memory responder.
//   re, we, funct3, addr, wdata : core -> memory
//   rdata, rvalid, stall        : memory -> core
//   misalign                    : memory -> core, only when
//                                 DMEM_MISALIGN_TRAP_EN is defined
interface dmem_ctrl_if;
    logic        re;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    modport master (
`ifdef DMEM_MISALIGN_TRAP_EN
        input  misalign,
`endif
        output re, we, funct3, addr, wdata,
        input  rdata, rvalid, stall
    );

    modport slave (
`ifdef DMEM_MISALIGN_TRAP_EN
        output misalign,
`endif
        input  re, we, funct3, addr, wdata,
        output rdata, rvalid, stall
    );
endinterface

// File: rtl/dmem_ctrl_array.sv
// dmem_array: 2**DEPTH_LOG x 32-bit word store.
//   clk   : clock
//   be    : per-byte write enable, written on the rising edge
//   idx   : word index, shared by read and write
//   wdata : write data (already lane-steered)
//   rdata : combinational read of word idx
// Contents are never reset.
module dmem_array #(
    parameter int DEPTH_LOG = 10
) (
    input  logic                 clk,
    input  logic [3:0]           be,
    input  logic [DEPTH_LOG-1:0] idx,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    logic [31:0] mem [0:(1<<DEPTH_LOG)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: fixed-latency data-memory responder for the pipelined core.
//   clk  : clock
//   nrst : synchronous active-low reset
//   bus  : dmem_ctrl_if.slave (re/we/funct3/addr/wdata in,
//          rdata/rvalid/stall[/misalign] out)
// Each access stalls the core for MEM_DELAY cycles, followed by one DONE
// cycle where loads present rvalid/rdata. Stores commit on the edge that
// enters DONE. Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses
// are flagged and suppressed instead of being aligned down.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG = 10,
    parameter int MEM_DELAY = MEM_DELAY_CONST
) (
    input  logic       clk,
    input  logic       nrst,
    dmem_ctrl_if.slave bus
);
    localparam int CW = $clog2(MEM_DELAY + 1);

    if (MEM_DELAY < 1) begin : g_bad_delay
        $error("dmem_ctrl: MEM_DELAY must be >= 1");
    end

    dmem_state_t state;
    logic [CW-1:0] cnt;
    logic        l_re, l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr, l_wdata;
    logic [31:0] rdata_q;

    logic        req, finish;
    logic        cur_re, cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata, eff_addr;
    logic        half, word, mis;
    logic [1:0]  lane;
    logic [31:0] rd_word, ld_data, st_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  st_be, arr_be;

    assign req = bus.re | bus.we;

    // In IDLE the live request is the access (it may finish on this very
    // edge when MEM_DELAY==1); afterwards the latched copy is used.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_re = bus.re;  cur_we = bus.we;  cur_f3 = bus.funct3;
            cur_addr = bus.addr;  cur_wdata = bus.wdata;
        end else begin
            cur_re = l_re;  cur_we = l_we;  cur_f3 = l_f3;
            cur_addr = l_addr;  cur_wdata = l_wdata;
        end
    end

    // Edge that moves the FSM into DONE: store commit / load capture.
    assign finish = ((state == ST_IDLE) && req && (MEM_DELAY == 1)) ||
                    ((state == ST_WAIT) && (32'(cnt) + 32'd1 == 32'(MEM_DELAY)));

    assign half = (cur_f3 == F3_LH) || (cur_f3 == F3_LHU);
    assign word = (cur_f3 == F3_LW);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis      = (half && cur_addr[0]) || (word && (cur_addr[1:0] != 2'b00));
    assign eff_addr = cur_addr;
`else
    assign mis      = 1'b0;
    assign eff_addr = {cur_addr[31:2], cur_addr[1] & ~word, cur_addr[0] & ~(half | word)};
`endif

    assign lane = eff_addr[1:0];

    always_comb begin
        byte_v = rd_word[{lane, 3'b000} +: 8];
        half_v = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_f3)
            F3_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
            F3_LH:   ld_data = {{16{half_v[15]}}, half_v};
            F3_LBU:  ld_data = {24'd0, byte_v};
            F3_LHU:  ld_data = {16'd0, half_v};
            default: ld_data = rd_word;   // lw and illegal encodings
        endcase
        if (mis) ld_data = '0;
    end

    always_comb begin
        case (cur_f3)
            F3_SB: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{cur_wdata[7:0]}};
            end
            F3_SH: begin
                st_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{cur_wdata[15:0]}};
            end
            F3_SW: begin
                st_be   = 4'b1111;
                st_data = cur_wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = cur_wdata;
            end
        endcase
    end

    // nrst gates the write so a reset on the commit edge drops the store.
    assign arr_be = (nrst && finish && cur_we && !mis) ? st_be : 4'b0000;

    dmem_array #(.DEPTH_LOG(DEPTH_LOG)) u_array (
        .clk   (clk),
        .be    (arr_be),
        .idx   (eff_addr[DEPTH_LOG+1:2]),
        .wdata (st_data),
        .rdata (rd_word)
    );

    logic unused_addr_hi;
    assign unused_addr_hi = ^eff_addr[31:DEPTH_LOG+2];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            l_re    <= 1'b0;
            l_we    <= 1'b0;
            l_f3    <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    l_re    <= bus.re;
                    l_we    <= bus.we;
                    l_f3    <= bus.funct3;
                    l_addr  <= bus.addr;
                    l_wdata <= bus.wdata;
                    cnt     <= CW'(1);
                    state   <= finish ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (finish) state <= ST_DONE;
                end
                default: state <= ST_IDLE;   // DONE ignores re/we
            endcase
            if (finish && cur_re && !cur_we) rdata_q <= ld_data;
        end
    end

    assign bus.stall  = ((state == ST_IDLE) && req) || (state == ST_WAIT);
    assign bus.rvalid = (state == ST_DONE) && l_re && !l_we;
    assign bus.rdata  = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign bus.misalign = (state == ST_DONE) && mis;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl (MEM_DELAY=4).
// Covers both builds; misalign expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if bus();

    dmem_ctrl #(.DEPTH_LOG(10), .MEM_DELAY(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    int          n_stall, n_rv, n_mis, rv_at;
    logic [31:0] last_rd;
    logic [9:0]  stall_pat, rv_pat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        bus.re = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
        bus.addr = '0; bus.wdata = '0;
    endtask

    // One access; request is dropped after the first edge. Samples 8
    // cycles mid-cycle (cycle 0 = request cycle).
    task automatic acc(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.re = r; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
        n_stall = 0; n_rv = 0; n_mis = 0; rv_at = -1; last_rd = 'x;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.stall) n_stall++;
            if (bus.rvalid) begin n_rv++; rv_at = i; last_rd = bus.rdata; end
`ifdef DMEM_MISALIGN_TRAP_EN
            if (bus.misalign) n_mis++;
`endif
            @(posedge clk);
            #2;
            if (i == 0) idle_in();
        end
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        acc(1'b1, 1'b0, f3, a, 32'h0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        acc(1'b0, 1'b1, f3, a, d);
    endtask

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
`endif
        nrst = 1'b1;

        // Known content at 0x40, then abandon a store to it mid-WAIT.
        store(F3_SW, 32'h40, 32'h0);
        @(negedge clk);
        bus.we = 1'b1; bus.funct3 = F3_SW; bus.addr = 32'h40; bus.wdata = 32'hDEADBEEF;
        #1;
        chk("abort_stall_c0", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #2;
        idle_in();
        nrst = 1'b0;                  // sampled at the end of stall cycle 2
        @(posedge clk);
        #2;
        nrst = 1'b1;
        #1;
        chk("abort_stall", 32'(bus.stall), 32'd0);
        repeat (5) @(posedge clk);
        load(F3_LW, 32'h40);
        chk("abort_mem", last_rd, 32'h0);

        // Store then load latency.
        store(F3_SW, 32'h10, 32'h800000F1);
        chk("sw_stalls", 32'(n_stall), 32'd4);
        chk("sw_rvalid", 32'(n_rv), 32'd0);
        load(F3_LW, 32'h10);
        chk("lw_stalls", 32'(n_stall), 32'd4);
        chk("lw_rvcount", 32'(n_rv), 32'd1);
        chk("lw_rvcycle", 32'(rv_at), 32'd4);
        chk("lw_data", last_rd, 32'h800000F1);
        chk("rdata_hold", bus.rdata, 32'h800000F1);

        // Extension.
        store(F3_SW, 32'h20, 32'h80F17F82);
        load(F3_LB, 32'h20);  chk("lb_20", last_rd, 32'hFFFFFF82);
        load(F3_LBU, 32'h20); chk("lbu_20", last_rd, 32'h00000082);
        load(F3_LB, 32'h21);  chk("lb_21", last_rd, 32'h0000007F);
        load(F3_LB, 32'h23);  chk("lb_23", last_rd, 32'hFFFFFF80);
        load(F3_LH, 32'h22);  chk("lh_22", last_rd, 32'hFFFF80F1);
        load(F3_LHU, 32'h22); chk("lhu_22", last_rd, 32'h000080F1);
        load(F3_LH, 32'h20);  chk("lh_20", last_rd, 32'h00007F82);
        load(3'b011, 32'h20); chk("ld_illegal", last_rd, 32'h80F17F82);

        // Byte enables and lane replication.
        store(F3_SW, 32'h30, 32'h11223344);
        store(F3_SB, 32'h31, 32'h000000AA);
        store(F3_SH, 32'h32, 32'h0000BEEF);
        load(F3_LW, 32'h30);  chk("be_merge", last_rd, 32'hBEEFAA44);
        store(3'b111, 32'h30, 32'hFFFFFFFF);
        load(F3_LW, 32'h30);  chk("st_illegal", last_rd, 32'hBEEFAA44);

        // re=we=1 behaves as a store.
        acc(1'b1, 1'b1, F3_SW, 32'h50, 32'h12345678);
        chk("rewe_rvalid", 32'(n_rv), 32'd0);
        chk("rewe_stalls", 32'(n_stall), 32'd4);
        load(F3_LW, 32'h50);  chk("rewe_data", last_rd, 32'h12345678);

        // Load held high through DONE: re-issues in the IDLE after DONE.
        @(negedge clk);
        bus.re = 1'b1; bus.funct3 = F3_LW; bus.addr = 32'h50;
        stall_pat = '0; rv_pat = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            stall_pat[i] = bus.stall;
            rv_pat[i]    = bus.rvalid;
            if (i == 9) idle_in();
            @(posedge clk);
            #2;
        end
        chk("b2b_stall", 32'(stall_pat), 32'(10'b0111101111));
        chk("b2b_rvalid", 32'(rv_pat), 32'(10'b1000010000));
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_quiet", 32'(bus.stall), 32'd0);

        // Address wrap: upper bits ignored.
        store(F3_SW, 32'h0000_1010, 32'h00000055);
        load(F3_LW, 32'h10);  chk("wrap", last_rd, 32'h00000055);

        // Misaligned accesses.
        store(F3_SW, 32'h41, 32'hCAFEF00D);
        chk("mis_sw_stalls", 32'(n_stall), 32'd4);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_sw_pulse", 32'(n_mis), 32'd1);
        load(F3_LW, 32'h40);  chk("mis_sw_mem", last_rd, 32'h0);
        load(F3_LW, 32'h12);
        chk("mis_lw_data", last_rd, 32'h0);
        chk("mis_lw_pulse", 32'(n_mis), 32'd1);
`else
        load(F3_LW, 32'h40);  chk("mis_sw_mem", last_rd, 32'hCAFEF00D);
        load(F3_LHU, 32'h43); chk("mis_lhu", last_rd, 32'h0000CAFE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
